uart_rx_frame: RTL and testbench
================================

Name: uart_rx_frame

Overview:
Serial receive front end of the UART path. It deserialises frames on UART_RX_IN: 1 start bit, 8 data bits LSB first, optional parity, 1 stop bit. It hands each byte, with a one-cycle valid pulse, to the system controller's command parser (0xAA/0xBB/0xCC/0xDD command bytes, addresses, operands). It reports parity and framing errors, which feed the top-level parity_error/framing_error outputs.

Parameters:
DATA_W, 8, data bits per frame
PRESC_W, 6, width of PRESCALE input

Ports:
UART_CLK  in  1  sampling clock; all logic on rising edge
RST_N  in  1  reset
RX_IN  in  1  serial line, idle high, asynchronous to UART_CLK
PRESCALE  in  PRESC_W  UART_CLK cycles per bit; legal 8, 16, 32
PAR_EN  in  1  1 = parity bit present
PAR_TYP  in  1  0 = even, 1 = odd
P_DATA  out  DATA_W  received byte; held until next valid frame
DATA_VLD  out  1  one-cycle pulse, frame error-free
PAR_ERR  out  1  one-cycle pulse, parity mismatch
STP_ERR  out  1  one-cycle pulse, stop bit sampled 0
BUSY  out  1  high while not in IDLE

Behaviour:
- Reset: RST_N, asynchronous, active-high. Clock: UART_CLK. While RST_N=1, all outputs are 0, the FSM is in IDLE, and the counters and synchroniser flops are forced to 1 (line idle).
- Input: RX_IN passes through a 2-flop synchroniser (rx_s). All references below use rx_s.
- Configuration capture: PRESCALE, PAR_EN and PAR_TYP are latched when leaving IDLE and held for the whole frame. A PRESCALE value below 8 is latched as 8.
- Counters:
  - edge_cnt runs 0..P-1, where P is the latched prescale, and wraps.
  - bit_cnt increments on each edge_cnt wrap.
- Sampling: samples are taken at edge_cnt = P/2-2, P/2-1 and P/2. The bit value is decided at edge_cnt = P/2+1.
- FSM states:
  - IDLE: on rx_s=0, go to START with edge_cnt=0, bit_cnt=0.
  - START: at the decision point, a bit value of 1 is a glitch; return to IDLE with no outputs. A value of 0 continues; go to DATA at wrap.
  - DATA: shift the decided bit into P_DATA-shadow bit[bit_cnt-1] (LSB first). After 8 bits, go to PARITY if PAR_EN=1, else STOP.
  - PARITY: compare the decided bit with the XOR of the shadow byte, XOR PAR_TYP. Record any mismatch internally.
  - STOP: at the decision point, evaluate the frame and go to IDLE immediately, without waiting for the bit end, so the next start edge has a half-bit margin.
- Frame end, in the cycle after the stop decision:
  - Parity mismatch: PAR_ERR=1.
  - Stop bit 0: STP_ERR=1.
  - Both errors can pulse together.
  - No error: DATA_VLD=1 and P_DATA is updated from the shadow register in the same cycle.
  - On any error, P_DATA is not updated and DATA_VLD stays 0.
- Latency: DATA_VLD rises N*P + P/2 + 2 cycles after rx_s first goes low. N is 10 with parity, 9 without.
- Back-to-back frames: a start edge arriving one cycle after the frame-end pulse is accepted.
- Reset mid-frame: the frame is aborted and no pulse is emitted. After release, the block waits for rx_s=0.
- RX_IN held low continuously after a stop error: the block re-enters START and keeps re-arming. No DATA_VLD is produced.

Optional Feature:
MAJORITY_VOTE_EN
- Defined: the decided bit is the 2-of-3 majority of the three samples.
- Undefined: the decided bit is the single sample at edge_cnt = P/2. The other two sample flops are removed.
- Decision timing and latency are identical in both builds.

Decomposition:
- Shared package uart_pkg holds:
  - the FSM state enum (IDLE, START, DATA, PARITY, STOP);
  - the constants DATA_W=8, PRESC_MIN=8, PAR_EVEN=0, PAR_ODD=1.
- One natural sub-module: uart_rx_sampler. It holds edge_cnt and the sample flops and outputs the decided bit plus decision and wrap strobes. The FSM, shift register and error checks stay in uart_rx_frame.

Test Plan:
- PRESCALE=32, PAR_EN=1, PAR_TYP=0, send 0xAA with parity 0 → one DATA_VLD pulse with P_DATA=0xAA, PAR_ERR=STP_ERR=0, at 10*32+18 cycles after rx_s falls.
- Same configuration, send 0x04 then 0x55 back-to-back with a single stop bit and no idle → two DATA_VLD pulses, P_DATA=0x04 then 0x55.
- Send 0x55 with parity bit forced to 1 (even mode) → PAR_ERR pulse, DATA_VLD=0, P_DATA unchanged from the prior value.
- Send 0xCC with stop bit 0 → STP_ERR pulse, no DATA_VLD. Then idle-high line and send 0x0A → recovers with P_DATA=0x0A.
- 10-cycle low glitch on RX_IN at PRESCALE=32 → returns to IDLE, BUSY drops within 20 cycles, no output pulses.
- PRESCALE=8, PAR_EN=0, send 0xDD; assert RST_N at bit 4 of a following 0x02 frame → first frame gives DATA_VLD with 0xDD; the aborted frame produces no pulses; 0x02 resent after release is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

  localparam int   DATA_W    = 8;
  localparam int   PRESC_MIN = 8;
  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  function automatic logic maj3(
    input logic a,
    input logic b,
    input logic c
  );
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Bit-period counter and mid-bit sampler; MAJORITY_VOTE_EN selects
// 2-of-3 voting instead of a single centre sample.
module uart_rx_sampler #(
  parameter int PRESC_W = 6
) (
  input  logic               UART_CLK,
  input  logic               RST_N,
  input  logic               rx_s,
  input  logic               run,
  input  logic               clr,
  input  logic [PRESC_W-1:0] presc,
  output logic               bit_o,
  output logic               dec_o,
  output logic               wrap_o
);
  import uart_pkg::*;

  logic [PRESC_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [PRESC_W-1:0] half;

  // dec_o marks the last sample; the bit lands one edge later
  always_comb begin
    half       = presc >> 1;
    wrap_o     = run && (edge_cnt_q == presc - 1'b1);
    dec_o      = run && (edge_cnt_q == half);
    edge_cnt_d = edge_cnt_q;
    if (clr || wrap_o)
      edge_cnt_d = '0;
    else if (run)
      edge_cnt_d = edge_cnt_q + 1'b1;
  end

  always_ff @(posedge UART_CLK or posedge RST_N)
    if (RST_N) edge_cnt_q <= '1;
    else       edge_cnt_q <= edge_cnt_d;

`ifdef MAJORITY_VOTE_EN
  logic s0_q, s0_d, s1_q, s1_d;

  always_comb begin
    s0_d = s0_q;
    s1_d = s1_q;
    if (run && edge_cnt_q == half - PRESC_W'(2))
      s0_d = rx_s;
    if (run && edge_cnt_q == half - PRESC_W'(1))
      s1_d = rx_s;
  end

  always_ff @(posedge UART_CLK or posedge RST_N)
    if (RST_N) begin
      s0_q <= 1'b1;
      s1_q <= 1'b1;
    end else begin
      s0_q <= s0_d;
      s1_q <= s1_d;
    end

  assign bit_o = maj3(s0_q, s1_q, rx_s);
`else
  assign bit_o = rx_s;
`endif

endmodule

// File: rtl/uart_rx_frame.sv
// UART frame receiver: start, 8 data LSB first, optional parity, stop.
// Build with MAJORITY_VOTE_EN for 2-of-3 bit voting in the sampler.
module uart_rx_frame #(
  parameter int DATA_W  = 8,
  parameter int PRESC_W = 6
) (
  input  logic               UART_CLK,
  input  logic               RST_N,
  input  logic               RX_IN,
  input  logic [PRESC_W-1:0] PRESCALE,
  input  logic               PAR_EN,
  input  logic               PAR_TYP,
  output logic [DATA_W-1:0]  P_DATA,
  output logic               DATA_VLD,
  output logic               PAR_ERR,
  output logic               STP_ERR,
  output logic               BUSY
);
  import uart_pkg::*;

  localparam int BW = $clog2(DATA_W + 3);
  localparam int IW = $clog2(DATA_W);

  logic               rx_meta_q, rx_s_q;
  rx_state_e          state_q, state_d;
  logic [BW-1:0]      bit_cnt_q, bit_cnt_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               par_en_q, par_en_d;
  logic               par_typ_q, par_typ_d;
  logic               par_bad_q, par_bad_d;
  logic [DATA_W-1:0]  shadow_q, shadow_d;
  logic [DATA_W-1:0]  p_data_q, p_data_d;
  logic               vld_q, vld_d;
  logic               perr_q, perr_d;
  logic               serr_q, serr_d;
  logic               start_go, bit_v, dec, wrap;

  assign start_go = (state_q == IDLE) && !rx_s_q;

  uart_rx_sampler #(.PRESC_W(PRESC_W)) u_sampler (
    .UART_CLK (UART_CLK),
    .RST_N    (RST_N),
    .rx_s     (rx_s_q),
    .run      (state_q != IDLE),
    .clr      (start_go),
    .presc    (presc_q),
    .bit_o    (bit_v),
    .dec_o    (dec),
    .wrap_o   (wrap)
  );

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = wrap ? bit_cnt_q + 1'b1 : bit_cnt_q;
    presc_d   = presc_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    par_bad_d = par_bad_q;
    shadow_d  = shadow_q;
    p_data_d  = p_data_q;
    vld_d     = 1'b0;
    perr_d    = 1'b0;
    serr_d    = 1'b0;
    unique case (state_q)
      IDLE: if (start_go) begin
        state_d   = START;
        bit_cnt_d = '0;
        presc_d   = (PRESCALE < PRESC_W'(PRESC_MIN))
                  ? PRESC_W'(PRESC_MIN) : PRESCALE;
        par_en_d  = PAR_EN;
        par_typ_d = PAR_TYP;
        par_bad_d = 1'b0;
      end
      START: begin
        if (dec && bit_v) state_d = IDLE;
        else if (wrap)    state_d = DATA;
      end
      DATA: begin
        if (dec)
          shadow_d[IW'(bit_cnt_q - 1'b1)] = bit_v;
        if (wrap && bit_cnt_q == BW'(DATA_W))
          state_d = par_en_q ? PARITY : STOP;
      end
      PARITY: begin
        if (dec)
          par_bad_d = bit_v
                   != ((^shadow_q) ^ (par_typ_q == PAR_ODD));
        if (wrap) state_d = STOP;
      end
      // leave mid stop bit so a following start edge is never missed
      STOP: if (dec) begin
        state_d = IDLE;
        serr_d  = !bit_v;
        perr_d  = par_bad_q;
        if (bit_v && !par_bad_q) begin
          vld_d    = 1'b1;
          p_data_d = shadow_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge UART_CLK or posedge RST_N)
    if (RST_N) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= IDLE;
      bit_cnt_q <= '1;
      presc_q   <= PRESC_W'(PRESC_MIN);
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      par_bad_q <= 1'b0;
      shadow_q  <= '0;
      p_data_q  <= '0;
      vld_q     <= 1'b0;
      perr_q    <= 1'b0;
      serr_q    <= 1'b0;
    end else begin
      rx_meta_q <= RX_IN;
      rx_s_q    <= rx_meta_q;
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      presc_q   <= presc_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      par_bad_q <= par_bad_d;
      shadow_q  <= shadow_d;
      p_data_q  <= p_data_d;
      vld_q     <= vld_d;
      perr_q    <= perr_d;
      serr_q    <= serr_d;
    end

  assign P_DATA   = p_data_q;
  assign DATA_VLD = vld_q;
  assign PAR_ERR  = perr_q;
  assign STP_ERR  = serr_q;
  assign BUSY     = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_frame.sv
// Self-checking bench for uart_rx_frame: frame table plus
// hand sequences for latency, glitch and mid-frame reset.
module tb_uart_rx_frame;

  logic       UART_CLK = 1'b0;
  logic       RST_N    = 1'b1;
  logic       RX_IN    = 1'b1;
  logic [5:0] PRESCALE = 6'd32;
  logic       PAR_EN   = 1'b1;
  logic       PAR_TYP  = 1'b0;
  logic [7:0] P_DATA;
  logic       DATA_VLD, PAR_ERR, STP_ERR, BUSY;

  uart_rx_frame dut (
    .UART_CLK (UART_CLK),
    .RST_N    (RST_N),
    .RX_IN    (RX_IN),
    .PRESCALE (PRESCALE),
    .PAR_EN   (PAR_EN),
    .PAR_TYP  (PAR_TYP),
    .P_DATA   (P_DATA),
    .DATA_VLD (DATA_VLD),
    .PAR_ERR  (PAR_ERR),
    .STP_ERR  (STP_ERR),
    .BUSY     (BUSY)
  );

  always #5 UART_CLK = ~UART_CLK;

  int cyc = 0;
  always @(posedge UART_CLK) cyc <= cyc + 1;

  typedef struct {
    logic       vld;
    logic       perr;
    logic       serr;
    logic [7:0] pdata;
  } exp_t;

  typedef struct {
    logic [7:0] d;
    int         presc;
    int         blen;
    logic       pen;
    logic       ptyp;
    logic       bpar;
    logic       bstop;
    int         gap;
  } vec_t;

  exp_t       sb[$];
  vec_t       tbl[11];
  int         checks   = 0;
  int         errors   = 0;
  logic [7:0] model_pd = 8'h00;
  int         fall_cyc = 0;
  int         vld_cyc  = -1;
  int         wait_n;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge UART_CLK);
      if (!RST_N && (DATA_VLD || PAR_ERR || STP_ERR)) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: vld=%0d perr=%0d serr=%0d, none expected",
                   DATA_VLD, PAR_ERR, STP_ERR);
        end else begin
          e = sb.pop_front();
          check("data_vld", DATA_VLD, e.vld);
          check("par_err", PAR_ERR, e.perr);
          check("stp_err", STP_ERR, e.serr);
          check("p_data", P_DATA, e.pdata);
          if (DATA_VLD) vld_cyc = cyc;
        end
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge UART_CLK);
    #1;
  endtask

  task automatic drive_bit(input logic b, input int blen);
    RX_IN = b;
    idle(blen);
  endtask

  task automatic send_frame(input logic [7:0] d, input int presc,
                            input int blen, input logic pen,
                            input logic ptyp, input logic bpar,
                            input logic bstop);
    exp_t e;
    PRESCALE = 6'(presc);
    PAR_EN   = pen;
    PAR_TYP  = ptyp;
    e.perr   = pen && bpar;
    e.serr   = bstop;
    e.vld    = !e.perr && !e.serr;
    if (e.vld) model_pd = d;
    e.pdata  = model_pd;
    sb.push_back(e);
    fall_cyc = cyc;
    drive_bit(1'b0, blen);
    for (int i = 0; i < 8; i++) drive_bit(d[i], blen);
    if (pen) drive_bit((^d) ^ ptyp ^ bpar, blen);
    drive_bit(!bstop, blen);
    RX_IN = 1'b1;
  endtask

  initial begin
    tbl[0]  = '{8'h04, 32, 32, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    tbl[1]  = '{8'h55, 32, 32, 1'b1, 1'b0, 1'b0, 1'b0, 8};
    tbl[2]  = '{8'h33, 32, 32, 1'b1, 1'b0, 1'b1, 1'b0, 8};
    tbl[3]  = '{8'h55, 32, 32, 1'b1, 1'b0, 1'b1, 1'b0, 8};
    tbl[4]  = '{8'hCC, 32, 32, 1'b1, 1'b0, 1'b0, 1'b1, 80};
    tbl[5]  = '{8'h0A, 32, 32, 1'b1, 1'b0, 1'b0, 1'b0, 8};
    tbl[6]  = '{8'h3C, 16, 16, 1'b1, 1'b1, 1'b0, 1'b0, 8};
    tbl[7]  = '{8'h81, 16, 16, 1'b1, 1'b1, 1'b1, 1'b0, 8};
    tbl[8]  = '{8'hC3, 32, 32, 1'b1, 1'b0, 1'b1, 1'b1, 80};
    tbl[9]  = '{8'h5A, 4, 8, 1'b1, 1'b0, 1'b0, 1'b0, 8};
    tbl[10] = '{8'hDD, 8, 8, 1'b0, 1'b0, 1'b0, 1'b0, 16};

    fork
      monitor();
    join_none

    idle(4);
    check("rst_p_data", P_DATA, 0);
    check("rst_data_vld", DATA_VLD, 0);
    check("rst_par_err", PAR_ERR, 0);
    check("rst_stp_err", STP_ERR, 0);
    check("rst_busy", BUSY, 0);
    RST_N = 1'b0;
    idle(5);

    // two synchroniser cycles precede rx_s falling
    send_frame(8'hAA, 32, 32, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(8);
    check("latency_aa", vld_cyc - fall_cyc, 10 * 32 + 18 + 2);

    for (int i = 0; i < 11; i++) begin
      send_frame(tbl[i].d, tbl[i].presc, tbl[i].blen, tbl[i].pen,
                 tbl[i].ptyp, tbl[i].bpar, tbl[i].bstop);
      idle(tbl[i].gap);
    end

    PRESCALE = 6'd32;
    PAR_EN   = 1'b1;
    idle(4);
    RX_IN = 1'b0;
    idle(10);
    RX_IN = 1'b1;
    check("glitch_busy_hi", BUSY, 1);
    idle(12);
    check("glitch_busy_lo", BUSY, 0);
    idle(40);

    PRESCALE = 6'd8;
    PAR_EN   = 1'b0;
    drive_bit(1'b0, 8);
    for (int i = 0; i < 4; i++) drive_bit(i == 1, 8);
    drive_bit(1'b0, 3);
    RST_N = 1'b1;
    RX_IN = 1'b1;
    idle(3);
    check("midrst_busy", BUSY, 0);
    check("midrst_p_data", P_DATA, 0);
    check("midrst_data_vld", DATA_VLD, 0);
    model_pd = 8'h00;
    RST_N = 1'b0;
    idle(10);
    check("midrst_idle", BUSY, 0);
    send_frame(8'h02, 8, 8, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(20);

    wait_n = 0;
    while (sb.size() != 0 && wait_n < 200) begin
      idle(1);
      wait_n++;
    end
    check("pending_pulses", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
